seq_pattern_tx: RTL and testbench

- Serial pattern transmitter: the transmit end of the single-bit serial stream that our sequence-detector FSMs consume.
- Loads a parallel pattern on a start request and emits it MSB-first, one bit per clock, repeated a programmable number of times.
- Raises a qualifying valid flag on every driven bit and a one-cycle done pulse at the end.
- Drives detector testbenches and on-chip loopback paths.

---
 rtl/seq_pattern_tx.sv | 139 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched word MSB-first, reps+1 times back to back.
// Optional build macro SEQTX_PARITY_EN appends an even-parity bit after every word.
`timescale 1ns/1ps
module seq_pattern_tx #(
  parameter int WIDTH  = 8,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  pattern,
  input  logic [REPS_W-1:0] reps,
  output logic              x_out,
  output logic              x_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SEQTX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t              state_r, state_nxt;
  logic [WIDTH-1:0]    shreg_r, shreg_nxt;
  logic [WIDTH-1:0]    pat_r;
  logic [REPS_W-1:0]   reps_r;
  logic [CNT_W-1:0]    bit_r, bit_nxt;
  logic [REPS_W-1:0]   rep_r, rep_nxt;
  logic                x_out_nxt, x_valid_nxt, busy_nxt, done_nxt;
  logic                load;
  logic                word_end;

  always_comb begin
    state_nxt   = state_r;
    shreg_nxt   = shreg_r;
    bit_nxt     = bit_r;
    rep_nxt     = rep_r;
    x_out_nxt   = 1'b0;
    x_valid_nxt = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    load        = 1'b0;
    word_end    = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          load        = 1'b1;
          state_nxt   = SHIFT;
          shreg_nxt   = pattern;
          bit_nxt     = '0;
          rep_nxt     = '0;
          x_out_nxt   = pattern[WIDTH-1];
          x_valid_nxt = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      SHIFT: begin
        busy_nxt = 1'b1;
        if (bit_r == LAST_BIT) begin
`ifdef SEQTX_PARITY_EN
          state_nxt   = PAR;
          x_out_nxt   = even_parity(pat_r);
          x_valid_nxt = 1'b1;
`else
          word_end    = 1'b1;
`endif
        end else begin
          shreg_nxt   = shreg_r << 1;
          bit_nxt     = bit_r + 1'b1;
          x_out_nxt   = shreg_r[WIDTH-2];
          x_valid_nxt = 1'b1;
        end
      end
`ifdef SEQTX_PARITY_EN
      PAR: begin
        busy_nxt = 1'b1;
        word_end = 1'b1;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // End of a word: either reload for the next repetition with no gap, or finish.
    if (word_end) begin
      if (rep_r < reps_r) begin
        state_nxt   = SHIFT;
        shreg_nxt   = pat_r;
        bit_nxt     = '0;
        rep_nxt     = rep_r + 1'b1;
        x_out_nxt   = pat_r[WIDTH-1];
        x_valid_nxt = 1'b1;
      end else begin
        state_nxt   = DONE;
        done_nxt    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      bit_r   <= '0;
      rep_r   <= '0;
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      bit_r   <= bit_nxt;
      rep_r   <= rep_nxt;
      x_out   <= x_out_nxt;
      x_valid <= x_valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Datapath holds no reset; it is always reloaded when a transfer is accepted.
  always_ff @(posedge clk) begin
    shreg_r <= shreg_nxt;
    if (load) begin
      pat_r  <= pattern;
      reps_r <= reps;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: per-cycle scoreboard of {x_valid,x_out,busy,done}.
`timescale 1ns/1ps
module tb_seq_pattern_tx;
  localparam int W  = 8;
  localparam int RW = 4;
`ifdef SEQTX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  pattern;
  logic [RW-1:0] reps;
  logic          x_out, x_valid, busy, done;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(W), .REPS_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
  );

  logic [3:0] exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    vcount = 0;
  int    dcount = 0;
  string tag = "init";

  always @(negedge clk) begin
    logic [3:0] e, g;
    vcount += int'(x_valid);
    dcount += int'(done);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {x_valid, x_out, busy, done};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s stream {valid,out,busy,done} got=%b want=%b at %0t", tag, g, e, $time);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push_word(input logic [W-1:0] p, input int nreps);
    for (int r = 0; r <= nreps; r++) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back({1'b1, p[i], 1'b1, 1'b0});
      if (PB == 1) exp_q.push_back({1'b1, ^p, 2'b10});
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endtask

  task automatic launch(input logic [W-1:0] p, input logic [RW-1:0] r);
    @(negedge clk);
    pattern = p;
    reps    = r;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending=%0d want=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  typedef struct {
    logic [W-1:0]  pat;
    logic [RW-1:0] reps;
    int            exp_words;
    int            exp_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int v0, d0, len;
    tbl[0] = '{8'hA5, 4'd0,  1,  1};
    tbl[1] = '{8'h81, 4'd2,  3,  1};
    tbl[2] = '{8'h3C, 4'd1,  2,  1};
    tbl[3] = '{8'h00, 4'd0,  1,  1};
    tbl[4] = '{8'hFF, 4'd3,  4,  1};
    tbl[5] = '{8'h5A, 4'd15, 16, 1};
    tbl[6] = '{8'h07, 4'd0,  1,  1};

    rst = 1'b1; start = 1'b0; pattern = '0; reps = '0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; pattern = 8'hFF;
    @(negedge clk);
    check("reset_outputs", {28'd0, x_valid, x_out, busy, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset_overrides_start", {28'd0, x_valid, x_out, busy, done}, 32'd0);
    #1 rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 7; i++) begin
      $sformat(tag, "vec%0d_%h_r%0d", i, tbl[i].pat, tbl[i].reps);
      v0 = vcount; d0 = dcount;
      launch(tbl[i].pat, tbl[i].reps);
      push_word(tbl[i].pat, int'(tbl[i].reps));
      drain(400);
      check({tag, "_valid_cycles"}, vcount - v0, tbl[i].exp_words * (W + PB));
      check({tag, "_done_count"}, dcount - d0, tbl[i].exp_done);
    end

    tag = "start_while_busy";
    v0 = vcount; d0 = dcount;
    launch(8'hA5, 4'd0);
    push_word(8'hA5, 0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; pattern = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    drain(100);
    repeat (3) @(posedge clk);
    check("busy_start_valid_cycles", vcount - v0, W + PB);
    check("busy_start_done_count", dcount - d0, 1);

    tag = "reset_mid";
    launch(8'h3C, 4'd0);
    for (int k = 0; k <= 4; k++) exp_q.push_back({1'b1, 8'h3C >> (W - 1 - k) & 8'h01 ? 1'b1 : 1'b0, 2'b10});
    exp_q.push_back(4'b0000);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drain(100);
    tag = "after_reset_C3";
    launch(8'hC3, 4'd0);
    push_word(8'hC3, 0);
    drain(100);

    tag = "back_to_back";
    len = W + PB;
    v0 = vcount; d0 = dcount;
    @(negedge clk);
    pattern = 8'h0F; reps = '0; start = 1'b1;
    @(posedge clk);
    push_word(8'h0F, 0);
    push_word(8'h0F, 0);
    exp_q.push_back(4'b0000);
    repeat (2 * len + 2) @(posedge clk);
    #1 start = 1'b0;
    drain(100);
    check("b2b_valid_cycles", vcount - v0, 2 * len);
    check("b2b_done_count", dcount - d0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

endmodule
